// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared types and constants for the BCD display scanner
package bcd_display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    localparam int NIBBLE_W = 4;
    localparam int ADD3_THRESHOLD = 5;
    localparam int ADD3_VALUE = 3;
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction
endpackage

// File: rtl/bcd_double_dabble.sv
// bcd_double_dabble: sequential shift-add-3 binary to packed BCD, one bit per clock
module bcd_double_dabble
    import bcd_display_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic [DATA_W-1:0]            value_i,
    output logic                         busy_o,
    output logic [DIGITS*NIBBLE_W-1:0]   bcd_o
);
    localparam int CW = cnt_w(DATA_W);
    localparam int BW = DIGITS * NIBBLE_W;
    state_t            state_q, state_n;
    logic [DATA_W-1:0] sh_q, sh_n;
    logic [BW-1:0]     scr_q, scr_n, adj, disp_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    assign busy_o = state_q != IDLE;
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++)
            adj[i*NIBBLE_W +: NIBBLE_W] = scr_q[i*NIBBLE_W +: NIBBLE_W] >= ADD3_THRESHOLD
                ? scr_q[i*NIBBLE_W +: NIBBLE_W] + NIBBLE_W'(ADD3_VALUE)
                : scr_q[i*NIBBLE_W +: NIBBLE_W];
        state_n = state_q;
        sh_n = sh_q;
        scr_n = scr_q;
        cnt_n = cnt_q;
        disp_n = bcd_o;
        unique case (state_q)
            IDLE: if (load_i) begin
                sh_n = value_i;
                scr_n = '0;
                cnt_n = CW'(DATA_W);
                state_n = SHIFT;
            end
            SHIFT: begin
                {scr_n, sh_n} = {adj, sh_q} << 1;
                cnt_n = cnt_q - 1'b1;
                state_n = cnt_q == CW'(1) ? COMMIT : SHIFT;
            end
            COMMIT: begin
                disp_n = scr_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // Display register only changes in COMMIT, so partial results never show
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q <= '0;
            scr_q <= '0;
            cnt_q <= '0;
            bcd_o <= '0;
        end else begin
            state_q <= state_n;
            sh_q <= sh_n;
            scr_q <= scr_n;
            cnt_q <= cnt_n;
            bcd_o <= disp_n;
        end
    end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: BCD conversion plus time-multiplexed digit scan for a common-anode display
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] value_i,
    output logic              busy_o,
    output logic [3:0]        bcd_o,
    output logic [DIGITS-1:0] digit_sel_o
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    logic [DIGITS*NIBBLE_W-1:0] disp;
    logic [RW-1:0]              rcnt_q;
    logic [IW-1:0]              idx_q, idx_n;
    logic                       wrap, blank;
    bcd_double_dabble #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_dd (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_i),
        .value_i(value_i),
        .busy_o (busy_o),
        .bcd_o  (disp)
    );
    always_comb begin
        wrap = rcnt_q == RW'(REFRESH_DIV - 1);
        idx_n = wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank = idx_n != '0 && (disp >> (idx_n * NIBBLE_W)) == '0;
`else
        blank = 1'b0;
`endif
    end
    // Outputs are registered from the next index so select and nibble move together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
            idx_q <= '0;
            bcd_o <= '0;
            digit_sel_o <= ~DIGITS'(1);
        end else begin
            rcnt_q <= wrap ? '0 : rcnt_q + 1'b1;
            idx_q <= idx_n;
            bcd_o <= disp[idx_n*NIBBLE_W +: NIBBLE_W];
            digit_sel_o <= ~(DIGITS'(1) << idx_n) | {DIGITS{blank}};
        end
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: model-based and directed checks of bcd_display_scanner
module tb_bcd_display_scanner;
    localparam int DATA_W = 8;
    localparam int DIGITS = 3;
    localparam int R = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [2:0] S1 = 3'b111, S2 = 3'b111;
`else
    localparam logic [2:0] S1 = 3'b101, S2 = 3'b011;
`endif
    logic clk = 0, rst = 1, load_i = 0, chk_en = 0;
    logic [DATA_W-1:0] value_i = '0;
    logic busy_o;
    logic [3:0] bcd_o;
    logic [DIGITS-1:0] digit_sel_o;
    int passed = 0, total = 0;
    int k, busy_cnt, disp, pend, m_idx, e_bcd;
    logic [2:0] e_sel;
    always #5 clk = ~clk;
    bcd_display_scanner #(.DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .load_i(load_i), .value_i(value_i),
        .busy_o(busy_o), .bcd_o(bcd_o), .digit_sel_o(digit_sel_o)
    );
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask
    function automatic int dig(input int v, input int i);
        int p = 1;
        for (int j = 0; j < i; j++) p *= 10;
        return (v / p) % 10;
    endfunction
    function automatic logic [2:0] exp_sel(input int idx, input int v);
        logic [2:0] s = ~(3'b001 << idx);
`ifdef LEADING_ZERO_BLANK_EN
        int p = 1;
        for (int j = 0; j < idx; j++) p *= 10;
        if (idx != 0 && v / p == 0) s = 3'b111;
`endif
        return s;
    endfunction
    // Model: k clocks since reset decide the scan position; a conversion is a
    // DATA_W+1 cycle busy window after which the decimal value becomes visible.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 0; busy_cnt <= 0; disp <= 0; pend <= 0; m_idx <= 0;
            e_bcd <= 0; e_sel <= 3'b110;
        end else begin
            k <= k + 1;
            m_idx <= ((k + 1) / R) % DIGITS;
            e_bcd <= dig(disp, ((k + 1) / R) % DIGITS);
            e_sel <= exp_sel(((k + 1) / R) % DIGITS, disp);
            if (busy_cnt == 0) begin
                if (load_i) begin
                    busy_cnt <= DATA_W + 1;
                    pend <= int'(value_i);
                end
            end else begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) disp <= pend;
            end
        end
    end
    always @(negedge clk) if (chk_en) begin
        chk("busy", int'(busy_o), int'(busy_cnt != 0));
        chk("bcd", int'(bcd_o), e_bcd);
        chk("sel", int'(digit_sel_o), int'(e_sel));
    end
    task automatic load(input int v);
        value_i = DATA_W'(v);
        load_i = 1;
        @(negedge clk);
        load_i = 0;
    endtask
    task automatic wait_idle(output int c);
        c = 0;
        while (busy_o && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask
    task automatic check_disp(input string nm, input int d2, input int d1, input int d0);
        int d[3] = '{-1, -1, -1};
        repeat (DIGITS * R) begin
            @(negedge clk);
            d[m_idx] = int'(bcd_o);
        end
        chk({nm, "_d0"}, d[0], d0);
        chk({nm, "_d1"}, d[1], d1);
        chk({nm, "_d2"}, d[2], d2);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int c;
        int l128[3] = '{8, 2, 1};
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_bcd", int'(bcd_o), 0);
        chk("rst_sel", int'(digit_sel_o), 3'b110);
        rst = 0;
        chk_en = 1;
        repeat (4) @(negedge clk);
        chk("scan_sel1", int'(digit_sel_o), int'(S1));
        repeat (4) @(negedge clk);
        chk("scan_sel2", int'(digit_sel_o), int'(S2));
        chk("scan_bcd", int'(bcd_o), 0);
        repeat (4) @(negedge clk);
        chk("scan_wrap", int'(digit_sel_o), 3'b110);
        load(255);
        chk("busy_rise", int'(busy_o), 1);
        wait_idle(c);
        chk("busy_len", c, 9);
        check_disp("v255", 2, 5, 5);
        load(99);
        repeat (2) @(negedge clk);
        load(7);
        wait_idle(c);
        check_disp("v99", 0, 9, 9);
        load(200);
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_bcd", int'(bcd_o), 0);
        chk("arst_sel", int'(digit_sel_o), 3'b110);
        @(negedge clk);
        rst = 0;
        check_disp("arst_disp", 0, 0, 0);
        load(42);
        wait_idle(c);
        check_disp("v42", 0, 4, 2);
        load(128);
        wait_idle(c);
        load(64);
        c = 0;
        while (busy_o && c < 100) begin
            chk("hold128", int'(bcd_o), l128[m_idx]);
            @(negedge clk);
            c++;
        end
        check_disp("v64", 0, 6, 4);
`ifdef LEADING_ZERO_BLANK_EN
        load(7);
        wait_idle(c);
        @(negedge clk);
        repeat (DIGITS * R) begin
            @(negedge clk);
            chk("blank7_sel", int'(digit_sel_o), m_idx == 0 ? 3'b110 : 3'b111);
            chk("blank7_bcd", int'(bcd_o), m_idx == 0 ? 7 : 0);
        end
        load(0);
        wait_idle(c);
        @(negedge clk);
        repeat (DIGITS * R) begin
            @(negedge clk);
            chk("blank0_sel", int'(digit_sel_o), m_idx == 0 ? 3'b110 : 3'b111);
            chk("blank0_bcd", int'(bcd_o), 0);
        end
`endif
        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
